hcsr04_echo_emulator: RTL and testbench

Emulates the sensor side of the HC-SR04 trig/echo protocol. It qualifies a trigger pulse, waits the transducer-burst delay, then drives an echo pulse whose width encodes a programmed target distance. It is used for hardware-in-loop and bench testing of the ultrasonic controller on the FPGA, with no physical sensor attached. The distance-to-width conversion is the exact inverse of the controller's conversion, distance_mm = floor(34*N/10000), where N is the echo width in 50 MHz cycles.

---
 rtl/hcsr04_echo_emulator_pkg.sv | 32 +++
 rtl/hcsr04_echo_emulator_trig_qualifier.sv | 69 ++++++
 rtl/hcsr04_echo_emulator.sv | 174 +++++++++++++++++
 tb/tb_hcsr04_echo_emulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_echo_emulator_pkg.sv
// Shared state encoding, distance conversion constants and default timing for the
// HC-SR04 echo emulator; the ultrasonic controller imports the same K_NUM/K_DEN.
package hcsr04_echo_emulator_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HI,
      BURST,
      ECHO,
      HOLDOFF
   } state_e;

   // distance_mm = floor(K_NUM * N / K_DEN), N = echo width in 50 MHz cycles
   localparam int unsigned K_NUM = 34;
   localparam int unsigned K_DEN = 10000;

   localparam int unsigned TRIG_MIN_CYCLES_DEF = 450;
   localparam int unsigned TRIG_MAX_CYCLES_DEF = 50000;
   localparam int unsigned BURST_CYCLES_DEF    = 10000;
   localparam int unsigned MAX_MM_DEF          = 4000;
   localparam int unsigned NO_OBJ_CYCLES_DEF   = 1900000;
   localparam int unsigned HOLDOFF_CYCLES_DEF  = 1000;

   localparam int unsigned CNT_W = 21;
   localparam int unsigned ACC_W = 14;
   localparam int unsigned MM_W  = 16;

   function automatic logic is_object(input logic [MM_W-1:0] d, input int unsigned max_mm);
      return (d != '0) && (32'(d) <= max_mm);
   endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_trig_qualifier.sv
// Trigger front end: 2-flop synchronizer, edge detection and a saturating
// high-width counter that classifies each trigger fall as valid or invalid.
module trig_qualifier
   import hcsr04_echo_emulator_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYCLES = TRIG_MIN_CYCLES_DEF,
   parameter int unsigned TRIG_MAX_CYCLES = TRIG_MAX_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic trig_i,
   output logic rise_o,
   output logic fall_valid_o,
   output logic fall_invalid_o
);

   localparam int unsigned      WID_W   = $clog2(TRIG_MAX_CYCLES + 2);
   localparam logic [WID_W-1:0] WID_SAT = WID_W'(TRIG_MAX_CYCLES + 1);
   localparam logic [WID_W-1:0] WID_MIN = WID_W'(TRIG_MIN_CYCLES);
   localparam logic [WID_W-1:0] WID_MAX = WID_W'(TRIG_MAX_CYCLES);

   logic             sync1_q;
   logic             trig_s_q;
   logic             trig_q;
   logic [1:0]       fill_q;
   logic             armed_q, armed_d;
   logic [WID_W-1:0] width_q, width_d;
   logic             fall;
   logic             width_ok;

   always_comb begin
      width_d = width_q;
      if (trig_s_q) begin
         if (!trig_q) begin
            width_d = WID_W'(1);
         end else if (width_q != WID_SAT) begin
            width_d = width_q + WID_W'(1);
         end
      end
      // Rises only count once trig_s has been seen low with a filled pipeline,
      // so a trigger already high when reset releases is ignored.
      armed_d  = armed_q | (fill_q[1] & ~trig_s_q);
      fall     = trig_q & ~trig_s_q;
      width_ok = (width_q >= WID_MIN) && (width_q <= WID_MAX);
   end

   assign rise_o         = trig_s_q & ~trig_q & armed_q;
   assign fall_valid_o   = fall & width_ok;
   assign fall_invalid_o = fall & ~width_ok;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         trig_s_q <= 1'b0;
         trig_q   <= 1'b0;
         fill_q   <= '0;
         armed_q  <= 1'b0;
         width_q  <= '0;
      end else begin
         sync1_q  <= trig_i;
         trig_s_q <= sync1_q;
         trig_q   <= trig_s_q;
         fill_q   <= {fill_q[0], 1'b1};
         armed_q  <= armed_d;
         width_q  <= width_d;
      end
   end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 sensor emulator: qualifies a trigger, waits the burst delay, then drives
// an echo whose width is the exact inverse of floor(34*N/10000) millimetres.
module hcsr04_echo_emulator
   import hcsr04_echo_emulator_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYCLES = TRIG_MIN_CYCLES_DEF,
   parameter int unsigned TRIG_MAX_CYCLES = TRIG_MAX_CYCLES_DEF,
   parameter int unsigned BURST_CYCLES    = BURST_CYCLES_DEF,
   parameter int unsigned MAX_MM          = MAX_MM_DEF,
   parameter int unsigned NO_OBJ_CYCLES   = NO_OBJ_CYCLES_DEF,
   parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
   input  logic            clk_50M,
   input  logic            reset,
   input  logic            trig_in,
   input  logic [MM_W-1:0] distance_mm,
   output logic            echo_out,
   output logic            busy,
   output logic            trig_err
);

   // Burst compares against BURST_CYCLES (not -1) to give the B+3 trig-to-echo latency.
   localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYCLES);
   localparam logic [CNT_W-1:0] NO_OBJ_LAST  = CNT_W'(NO_OBJ_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [ACC_W-1:0] ACC_STEP     = ACC_W'(K_NUM);
   localparam logic [ACC_W-1:0] ACC_DEN      = ACC_W'(K_DEN);

   logic trig_rise;
   logic fall_valid;
   logic fall_invalid;

   trig_qualifier #(
      .TRIG_MIN_CYCLES(TRIG_MIN_CYCLES),
      .TRIG_MAX_CYCLES(TRIG_MAX_CYCLES)
   ) u_trig_qualifier (
      .clk_i         (clk_50M),
      .rst_ni        (reset),
      .trig_i        (trig_in),
      .rise_o        (trig_rise),
      .fall_valid_o  (fall_valid),
      .fall_invalid_o(fall_invalid)
   );

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  acc_sum;
   logic              acc_wrap;
   logic [MM_W-1:0]   mm_q, mm_d;
   logic [MM_W-1:0]   mm_next;
   logic [MM_W-1:0]   d_lat_q, d_lat_d;
   logic              obj_q, obj_d;
   logic              echo_q, echo_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   always_comb begin
      acc_sum  = acc_q + ACC_STEP;
      acc_wrap = (acc_sum >= ACC_DEN);
      mm_next  = mm_q + {{(MM_W-1){1'b0}}, acc_wrap};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mm_d    = mm_q;
      d_lat_d = d_lat_q;
      obj_d   = obj_q;
      echo_d  = echo_q;
      busy_d  = busy_q;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (trig_rise) begin
               state_d = TRIG_HI;
            end
         end

         TRIG_HI: begin
            if (fall_valid) begin
               d_lat_d = distance_mm;
               obj_d   = is_object(distance_mm, MAX_MM);
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = BURST;
            end else if (fall_invalid) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end

         BURST: begin
            if (cnt_q == BURST_LAST) begin
               echo_d  = 1'b1;
               cnt_d   = '0;
               acc_d   = '0;
               mm_d    = '0;
               state_d = ECHO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ECHO: begin
            if (obj_q) begin
               // Fractional mm accumulator; the echo ends on the cycle the
               // whole-mm count reaches the latched distance.
               acc_d = acc_wrap ? (acc_sum - ACC_DEN) : acc_sum;
               mm_d  = mm_next;
               if (acc_wrap && (mm_next == d_lat_q)) begin
                  echo_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = HOLDOFF;
               end
            end else if (cnt_q == NO_OBJ_LAST) begin
               echo_d  = 1'b0;
               cnt_d   = '0;
               state_d = HOLDOFF;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         HOLDOFF: begin
            if (cnt_q == HOLDOFF_LAST) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            echo_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mm_q    <= '0;
         d_lat_q <= '0;
         obj_q   <= 1'b0;
         echo_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mm_q    <= mm_d;
         d_lat_q <= d_lat_d;
         obj_q   <= obj_d;
         echo_q  <= echo_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign echo_out = echo_q;
   assign busy     = busy_q;
   assign trig_err = err_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Self-checking bench for hcsr04_echo_emulator, run with shortened timing parameters.
module tb_hcsr04_echo_emulator;

   localparam int unsigned T_MIN  = 20;
   localparam int unsigned T_MAX  = 200;
   localparam int unsigned BURST  = 100;
   localparam int unsigned MAXMM  = 70;
   localparam int unsigned NOOBJ  = 1500;
   localparam int unsigned HOLD   = 50;
   localparam int unsigned KLIMIT = 26000;

   logic        clk_50M;
   logic        reset;
   logic        trig_in;
   logic [15:0] distance_mm;
   logic        echo_out;
   logic        busy;
   logic        trig_err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   hcsr04_echo_emulator #(
      .TRIG_MIN_CYCLES(T_MIN),
      .TRIG_MAX_CYCLES(T_MAX),
      .BURST_CYCLES   (BURST),
      .MAX_MM         (MAXMM),
      .NO_OBJ_CYCLES  (NOOBJ),
      .HOLDOFF_CYCLES (HOLD)
   ) dut (
      .clk_50M    (clk_50M),
      .reset      (reset),
      .trig_in    (trig_in),
      .distance_mm(distance_mm),
      .echo_out   (echo_out),
      .busy       (busy),
      .trig_err   (trig_err)
   );

   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   typedef struct {
      int unsigned p;
      logic [15:0] d;
      bit          acc;
      int unsigned w;
   } vec_t;

   vec_t vecs[10];

   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Reference: echo width is ceil(10000*d/34) for an object, else the no-object width.
   function automatic int unsigned model_width(input longint d);
      if (d >= 1 && d <= MAXMM) return int'((d * 10000 + 33) / 34);
      return NOOBJ;
   endfunction

   // mode 0: plain trig; 1: extra trig + distance change during echo; 2: reset during echo
   task automatic run_trig(input string name, input int unsigned p, input logic [15:0] d,
                           input bit exp_acc, input int unsigned exp_w,
                           input int mode, input int unsigned inj);
      int unsigned k, rise_k, echo_w, busy_n, err_n, err_k, rises;
      bit prev, timeout, done;
      k = 0; rise_k = 0; echo_w = 0; busy_n = 0; err_n = 0; err_k = 0; rises = 0;
      prev = 1'b0; timeout = 1'b0; done = 1'b0;
      @(negedge clk_50M);
      distance_mm = d;
      trig_in     = 1'b1;
      repeat (p) @(negedge clk_50M);
      trig_in = 1'b0;
      while (!done) begin
         @(negedge clk_50M);
         if (echo_out && !prev) begin
            rises++;
            if (rises == 1) rise_k = k;
         end
         prev = echo_out;
         if (echo_out) echo_w++;
         if (busy) busy_n++;
         if (trig_err) begin
            err_n++;
            err_k = k;
         end
         if (mode == 1) begin
            trig_in = (k >= inj) && (k < inj + 50);
            if (k == inj) distance_mm = ~d;
         end
         if (mode == 2 && k == inj) begin
            check({name, " echo before reset"}, echo_out, 1);
            reset = 1'b0;
            @(negedge clk_50M);
            check({name, " echo at reset"}, echo_out, 0);
            check({name, " busy at reset"}, busy, 0);
            check({name, " err at reset"}, trig_err, 0);
            reset = 1'b1;
            return;
         end
         if (k > 10 && !busy && !echo_out && !trig_in) done = 1'b1;
         else if (k > KLIMIT) begin
            timeout = 1'b1;
            done    = 1'b1;
         end
         k++;
      end
      check({name, " timeout"}, timeout, 0);
      if (exp_acc) begin
         check({name, " echo latency"}, rise_k, BURST + 3);
         check({name, " echo width"}, echo_w, exp_w);
         check({name, " echo pulses"}, rises, 1);
         check({name, " busy length"}, busy_n, BURST + 1 + exp_w + HOLD);
         check({name, " trig_err count"}, err_n, 0);
      end else begin
         check({name, " trig_err count"}, err_n, 1);
         check({name, " trig_err timing"}, err_k, 2);
         check({name, " echo pulses"}, rises, 0);
         check({name, " busy length"}, busy_n, 0);
      end
   endtask

   initial begin
      int unsigned busy_seen, err_seen;
      reset       = 1'b0;
      trig_in     = 1'b0;
      distance_mm = '0;

      vecs[0] = '{19,  16'd5,     1'b0, 0};
      vecs[1] = '{20,  16'd1,     1'b1, 295};
      vecs[2] = '{200, 16'd2,     1'b1, 589};
      vecs[3] = '{201, 16'd2,     1'b0, 0};
      vecs[4] = '{600, 16'd3,     1'b0, 0};
      vecs[5] = '{50,  16'd0,     1'b1, 1500};
      vecs[6] = '{50,  16'd70,    1'b1, 20589};
      vecs[7] = '{50,  16'd71,    1'b1, 1500};
      vecs[8] = '{60,  16'hFFFF,  1'b1, 1500};
      vecs[9] = '{35,  16'd17,    1'b1, 5000};

      repeat (3) @(negedge clk_50M);
      check("reset echo_out", echo_out, 0);
      check("reset busy", busy, 0);
      check("reset trig_err", trig_err, 0);
      reset = 1'b1;
      repeat (10) @(negedge clk_50M);

      for (int i = 0; i < 10; i++) begin
         run_trig($sformatf("vec%0d", i), vecs[i].p, vecs[i].d, vecs[i].acc, vecs[i].w, 0, 0);
         repeat (5) @(negedge clk_50M);
      end

      for (int i = 0; i < 10; i++) begin
         int unsigned p, sel;
         logic [15:0] d;
         p   = $urandom_range(T_MAX + 30, 5);
         sel = $urandom_range(3, 0);
         case (sel)
            0:       d = 16'($urandom_range(4, 0));
            1:       d = 16'($urandom_range(80, 71));
            2:       d = 16'($urandom_range(65535, 0));
            default: d = 16'($urandom_range(4, 1));
         endcase
         run_trig($sformatf("rand%0d p=%0d d=%0d", i, p, d), p, d,
                  (p >= T_MIN) && (p <= T_MAX), model_width(d), 0, 0);
         repeat (1 + $urandom_range(5, 0)) @(negedge clk_50M);
      end

      run_trig("trig during echo", 40, 16'd5, 1'b1, 1471, 1, BURST + 3 + 200);
      repeat (3) @(negedge clk_50M);
      run_trig("trig after holdoff", 40, 16'd2, 1'b1, 589, 0, 0);
      repeat (5) @(negedge clk_50M);

      run_trig("reset mid echo", 40, 16'd10, 1'b1, 2942, 2, BURST + 3 + 500);
      repeat (10) @(negedge clk_50M);
      run_trig("after reset", 40, 16'd3, 1'b1, 883, 0, 0);
      repeat (5) @(negedge clk_50M);

      busy_seen   = 0;
      err_seen    = 0;
      distance_mm = 16'd4;
      trig_in     = 1'b1;
      reset       = 1'b0;
      repeat (2) @(negedge clk_50M);
      reset = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_50M);
         if (c == 40) trig_in = 1'b0;
         if (busy) busy_seen++;
         if (trig_err) err_seen++;
      end
      check("held trig busy cycles", busy_seen, 0);
      check("held trig err pulses", err_seen, 0);
      run_trig("after held trig", 25, 16'd4, 1'b1, 1177, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
